// File: rtl/emu_pkg.sv
// Shared types and constants for the co-emulation transactor.
package emu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAP  = 2'd2
  } emu_state_t;

  localparam int unsigned EMU_DW = 8;
  localparam int unsigned EMU_AW = 3;

  // STATUS register address for the default host address width
  localparam logic [EMU_AW-1:0] ADDR_STATUS = {EMU_AW{1'b1}};

  // STATUS flag positions, counted down from the MSB of the data byte
  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;

endpackage

// File: rtl/emu_step_ctrl.sv
// Step sequencer: runs the DUT clock enable for a programmed number of
// cycles, then optionally requests an output capture.
module emu_step_ctrl
  import emu_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned AUTO_CAP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] count,
  output logic          dut_clk_en,
  output logic          busy,
  output logic          done,
  output logic          cap_pulse
);

  emu_state_t    state, state_n;
  logic [DW-1:0] cnt, cnt_n;
  logic          done_n;

  // Next-state, counter and done-flag logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = done;
    unique case (state)
      IDLE: begin
        if (start && (count != '0)) begin
          state_n = RUN;
          cnt_n   = count;
          done_n  = 1'b0;
        end
      end
      RUN: begin
        cnt_n = cnt - DW'(1);
        if (cnt == DW'(1)) begin
          if (AUTO_CAP != 0) begin
            state_n = CAP;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      CAP: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      done       <= 1'b0;
      dut_clk_en <= 1'b0;
      busy       <= 1'b0;
      cap_pulse  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      done       <= done_n;
      dut_clk_en <= (state_n == RUN);
      busy       <= (state_n != IDLE);
      cap_pulse  <= (state_n == CAP);
    end
  end

endmodule

// File: rtl/emu_xactor.sv
// Co-emulation transactor: host byte bus to DUT stimulus/capture buffers,
// with a gated-clock step sequencer.
module emu_xactor
  import emu_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned N_STIM   = 2,
  parameter int unsigned N_OUT    = 2,
  parameter int unsigned AW       = 3,
  parameter int unsigned AUTO_CAP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DW-1:0]        din,
  input  logic [AW-1:0]        addr,
  input  logic                 wr_emu,
  input  logic                 load_emu,
  input  logic                 get_emu,
  input  logic                 step_emu,
  output logic [DW-1:0]        dout,
  output logic [N_STIM*DW-1:0] stim_o,
  input  logic [N_OUT*DW-1:0]  dut_out_i,
  output logic                 dut_clk_en,
  output logic                 busy
);

  localparam logic [AW-1:0] ADDR_ST = {AW{1'b1}};

  logic [N_STIM*DW-1:0] stim_buf;
  logic [N_OUT*DW-1:0]  vect_buf;
  logic                 do_load, do_get, do_step, do_wr;
  logic                 done, cap_pulse;
  logic [DW-1:0]        status, rd_data;

  // Command priority: load > get > step > wr; lower ones are masked even
  // when a higher one is being ignored because a step is running.
  always_comb begin
    do_load = load_emu & ~busy;
    do_get  = ~load_emu & get_emu & ~busy;
    do_step = ~load_emu & ~get_emu & step_emu;
    do_wr   = ~load_emu & ~get_emu & ~step_emu & wr_emu;
  end

  emu_step_ctrl #(
    .DW       (DW),
    .AUTO_CAP (AUTO_CAP)
  ) u_step_ctrl (
    .clk        (clk),
    .reset      (reset),
    .start      (do_step),
    .count      (din),
    .dut_clk_en (dut_clk_en),
    .busy       (busy),
    .done       (done),
    .cap_pulse  (cap_pulse)
  );

  // Read mux: capture slots, STATUS at all-ones, zero elsewhere
  always_comb begin
    status                = '0;
    status[DW-1-ST_BUSY]  = busy;
    status[DW-1-ST_DONE]  = done;
    rd_data               = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (addr == AW'(k)) rd_data = vect_buf[k*DW +: DW];
    end
    if (addr == ADDR_ST) rd_data = status;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stim_buf <= '0;
      stim_o   <= '0;
      vect_buf <= '0;
      dout     <= '0;
    end else begin
      dout <= rd_data;
      if (do_load) stim_o <= stim_buf;
      if (do_get || cap_pulse) vect_buf <= dut_out_i;
      if (do_wr) begin
        for (int k = 0; k < N_STIM; k++) begin
          if (addr == AW'(k)) stim_buf[k*DW +: DW] <= din;
        end
      end
    end
  end

endmodule

// File: tb/tb_emu_xactor.sv
// Scenario bench for emu_xactor: register reads are queued as expectations
// when issued and compared when dout answers one cycle later.
module tb_emu_xactor;
  import emu_pkg::*;

  localparam int unsigned DW     = 8;
  localparam int unsigned N_STIM = 2;
  localparam int unsigned N_OUT  = 2;
  localparam int unsigned AW     = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [DW-1:0]        din;
  logic [AW-1:0]        addr;
  logic                 wr_emu, load_emu, get_emu, step_emu;
  logic [DW-1:0]        dout;
  logic [N_STIM*DW-1:0] stim_o;
  logic [N_OUT*DW-1:0]  dut_out_i;
  logic                 dut_clk_en;
  logic                 busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  emu_xactor #(
    .DW(DW), .N_STIM(N_STIM), .N_OUT(N_OUT), .AW(AW), .AUTO_CAP(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .addr       (addr),
    .wr_emu     (wr_emu),
    .load_emu   (load_emu),
    .get_emu    (get_emu),
    .step_emu   (step_emu),
    .dout       (dout),
    .stim_o     (stim_o),
    .dut_out_i  (dut_out_i),
    .dut_clk_en (dut_clk_en),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cmds;
    wr_emu = 1'b0; load_emu = 1'b0; get_emu = 1'b0; step_emu = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] e;
    reset = 1'b1; idle_cmds(); din = '0; addr = '0; dut_out_i = '0;
    tick(); tick();
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %02h expected 00", dout); end
    n_checks++; if (stim_o !== 16'h0000) begin n_fail++; $display("FAIL reset_stim_o: got %04h expected 0000", stim_o); end
    n_checks++; if (dut_clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en: got %b expected 0", dut_clk_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    addr = ADDR_STATUS; exp_q.push_back(8'h00); tick();
    e = exp_q.pop_front();
    n_checks++; if (dout !== e) begin n_fail++; $display("FAIL reset_status: got %02h expected %02h", dout, e); end
  endtask

  task automatic test_load;
    idle_cmds();
    wr_emu = 1'b1; addr = 3'd0; din = 8'h5A; tick();
    addr = 3'd1; din = 8'h3C; tick();
    idle_cmds();
    n_checks++; if (stim_o !== 16'h0000) begin n_fail++; $display("FAIL load_before: got %04h expected 0000", stim_o); end
    load_emu = 1'b1; tick(); idle_cmds();
    n_checks++; if (stim_o !== 16'h3C5A) begin n_fail++; $display("FAIL load_after: got %04h expected 3c5a", stim_o); end
    wr_emu = 1'b1; addr = 3'd5; din = 8'hFF; tick(); idle_cmds();
    load_emu = 1'b1; tick(); idle_cmds();
    n_checks++; if (stim_o !== 16'h3C5A) begin n_fail++; $display("FAIL load_wr_oob: got %04h expected 3c5a", stim_o); end
  endtask

  task automatic test_step;
    logic [2:0] ra [3];
    logic [7:0] re [3];
    logic [7:0] e;
    int en_n = 0, busy_n = 0;
    ra = '{3'd0, 3'd1, 3'd7};
    re = '{8'h01, 8'hA5, 8'h40};
    idle_cmds(); dut_out_i = 16'hA501;
    step_emu = 1'b1; din = 8'd3; tick(); idle_cmds();
    for (int c = 0; c < 20 && busy === 1'b1; c++) begin
      en_n += int'(dut_clk_en);
      busy_n++;
      tick();
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL step_timeout: busy got %b expected 0", busy); end
    n_checks++; if (en_n != 3) begin n_fail++; $display("FAIL step_en_cycles: got %0d expected 3", en_n); end
    n_checks++; if (busy_n != 4) begin n_fail++; $display("FAIL step_busy_cycles: got %0d expected 4", busy_n); end
    dut_out_i = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      addr = ra[k]; exp_q.push_back(re[k]); tick();
      e = exp_q.pop_front();
      n_checks++; if (dout !== e) begin n_fail++; $display("FAIL step_read[%0d]: got %02h expected %02h", k, dout, e); end
    end
  endtask

  task automatic test_ignore;
    logic [2:0] ra [3];
    logic [7:0] re [3];
    logic [7:0] e;
    int en_n = 0, busy_n = 0;
    ra = '{3'd0, 3'd1, 3'd7};
    re = '{8'h34, 8'h12, 8'h40};
    idle_cmds(); dut_out_i = 16'h1234;
    step_emu = 1'b1; din = 8'd0; tick(); idle_cmds();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_step_busy: got %b expected 0", busy); end
    tick();
    n_checks++; if (dut_clk_en !== 1'b0) begin n_fail++; $display("FAIL zero_step_en: got %b expected 0", dut_clk_en); end
    for (int i = 0; i < 16; i++) begin
      idle_cmds(); dut_out_i = 16'h1234;
      case (i)
        0: begin step_emu = 1'b1; din = 8'd4; end
        1: load_emu = 1'b1;
        2: begin get_emu = 1'b1; dut_out_i = 16'hBEEF; end
        3: begin step_emu = 1'b1; din = 8'd9; end
        4: begin wr_emu = 1'b1; addr = 3'd0; din = 8'h77; end
        default: ;
      endcase
      tick();
      en_n   += int'(dut_clk_en);
      busy_n += int'(busy);
    end
    idle_cmds();
    n_checks++; if (en_n != 4) begin n_fail++; $display("FAIL busy_en_cycles: got %0d expected 4", en_n); end
    n_checks++; if (busy_n != 5) begin n_fail++; $display("FAIL busy_busy_cycles: got %0d expected 5", busy_n); end
    n_checks++; if (stim_o !== 16'h3C5A) begin n_fail++; $display("FAIL busy_load_ignored: got %04h expected 3c5a", stim_o); end
    for (int k = 0; k < 3; k++) begin
      addr = ra[k]; exp_q.push_back(re[k]); tick();
      e = exp_q.pop_front();
      n_checks++; if (dout !== e) begin n_fail++; $display("FAIL busy_read[%0d]: got %02h expected %02h", k, dout, e); end
    end
  endtask

  task automatic test_priority;
    logic [2:0] ra [6];
    logic [7:0] re [6];
    logic [7:0] e;
    ra = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd7};
    re = '{8'h34, 8'h12, 8'h00, 8'hFE, 8'hCA, 8'h40};
    idle_cmds(); dut_out_i = 16'hCAFE;
    load_emu = 1'b1; get_emu = 1'b1; tick(); idle_cmds();
    n_checks++; if (stim_o !== 16'h3C77) begin n_fail++; $display("FAIL prio_load_stim: got %04h expected 3c77", stim_o); end
    for (int k = 0; k < 3; k++) begin
      addr = ra[k]; exp_q.push_back(re[k]); tick();
      e = exp_q.pop_front();
      n_checks++; if (dout !== e) begin n_fail++; $display("FAIL prio_read[%0d]: got %02h expected %02h", k, dout, e); end
    end
    get_emu = 1'b1; step_emu = 1'b1; din = 8'd2; tick(); idle_cmds();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_get_over_step: busy got %b expected 0", busy); end
    for (int k = 3; k < 6; k++) begin
      addr = ra[k]; exp_q.push_back(re[k]); tick();
      e = exp_q.pop_front();
      n_checks++; if (dout !== e) begin n_fail++; $display("FAIL prio_read[%0d]: got %02h expected %02h", k, dout, e); end
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] ra [3];
    logic [7:0] e;
    ra = '{3'd0, 3'd1, 3'd7};
    idle_cmds(); dut_out_i = 16'h5555;
    step_emu = 1'b1; din = 8'd5; tick(); idle_cmds();
    n_checks++; if (dut_clk_en !== 1'b1) begin n_fail++; $display("FAIL mid_en_running: got %b expected 1", dut_clk_en); end
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (dut_clk_en !== 1'b0) begin n_fail++; $display("FAIL mid_en_after_reset: got %b expected 0", dut_clk_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_after_reset: got %b expected 0", busy); end
    n_checks++; if (stim_o !== 16'h0000) begin n_fail++; $display("FAIL mid_stim_after_reset: got %04h expected 0000", stim_o); end
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || dut_clk_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_no_resume: busy/en got %b/%b expected 0/0", busy, dut_clk_en);
    end
    for (int k = 0; k < 3; k++) begin
      addr = ra[k]; exp_q.push_back(8'h00); tick();
      e = exp_q.pop_front();
      n_checks++; if (dout !== e) begin n_fail++; $display("FAIL mid_read[%0d]: got %02h expected %02h", k, dout, e); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_step();
    test_ignore();
    test_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
